// File: rtl/icache_pkg.sv
// Shared constants, types and geometry helpers for the instruction cache.
package icache_pkg;

    localparam int LINE_WORDS  = 8;
    localparam int OFFSET_BITS = 3;
    localparam int LINE_BITS   = 256;

    // Line bytes are addressed by addr[4:0]; everything above splits into index and tag.
    localparam int LINE_ADDR_LSB = 5;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    function automatic int index_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_bits(input int num_lines);
        return 32 - LINE_ADDR_LSB - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// One combinational read port (word and its successor), one line-wide write port.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 64,
    parameter int IDX_W     = index_bits(NUM_LINES),
    parameter int TAG_W     = tag_bits(NUM_LINES)
) (
    input  logic                   clk,
    input  logic                   clr_all,
    input  logic [IDX_W-1:0]       rd_index,
    input  logic [OFFSET_BITS-1:0] rd_offset,
    output logic                   rd_valid,
    output logic [TAG_W-1:0]       rd_tag,
    output logic [31:0]            rd_word0,
    output logic [31:0]            rd_word1,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_index,
    input  logic [TAG_W-1:0]       wr_tag,
    input  logic [LINE_BITS-1:0]   wr_line,
    input  logic                   wr_valid
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_BITS-1:0] data_mem [NUM_LINES];

    logic [LINE_BITS-1:0]   rd_line;
    logic [OFFSET_BITS-1:0] next_offset;

    // Valid bits: clear-all first, then the single write so a same-edge write lands on top.
    always_comb begin
        valid_d = valid_q;
        if (clr_all) begin
            valid_d = '0;
        end
        if (wr_en) begin
            valid_d[wr_index] = wr_valid;
        end
    end

    // Valid vector register; cleared through clr_all, which the top asserts during reset.
    always_ff @(posedge clk) begin
        valid_q <= valid_d;
    end

    // Tag and data arrays written on refill.
    // NOTE: tag/data arrays are deliberately not reset; a cleared valid bit makes their contents don't-care.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_line;
        end
    end

    // Combinational read: selected word and the following word within the same line.
    always_comb begin
        rd_line     = data_mem[rd_index];
        next_offset = rd_offset + 1'b1;
        rd_word0    = '0;
        rd_word1    = '0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            if (rd_offset == OFFSET_BITS'(k)) begin
                rd_word0 = rd_line[32*k +: 32];
            end
            if (next_offset == OFFSET_BITS'(k)) begin
                rd_word1 = rd_line[32*k +: 32];
            end
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hits, blocking 8-word line refill.
module icache
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 64
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          Instr_address_2IC,
    input  logic                 flush_2IC,
    output logic [31:0]          Instr1_fIC,
    output logic [31:0]          Instr2_fIC,
    output logic                 Instr_valid_fIC,
    output logic                 Instr2_valid_fIC,
    output logic [31:0]          Instr_address_2IM,
    output logic                 iBlkRead,
    input  logic [LINE_BITS-1:0] block_read_fIM,
    input  logic                 block_read_fIM_valid
);

    localparam int IDX_W = index_bits(NUM_LINES);
    localparam int TAG_W = tag_bits(NUM_LINES);

    // Fetch address split.
    logic [OFFSET_BITS-1:0] req_offset;
    logic [IDX_W-1:0]       req_index;
    logic [TAG_W-1:0]       req_tag;

    assign req_offset = Instr_address_2IC[LINE_ADDR_LSB-1:2];
    assign req_index  = Instr_address_2IC[LINE_ADDR_LSB +: IDX_W];
    assign req_tag    = Instr_address_2IC[31 -: TAG_W];

    // Byte-within-word bits are architecturally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^Instr_address_2IC[1:0];

    state_e      state_q, state_d;
    logic [31:5] fill_addr_q, fill_addr_d;
    logic        discard_q, discard_d;
    logic        iblk_read_q, iblk_read_d;
    logic [31:0] addr_im_q, addr_im_d;

    logic        rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0] rd_word0, rd_word1;
    logic        hit;
    logic        wr_en, wr_valid;

    icache_line_store #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_store (
        .clk       (CLK),
        .clr_all   (RESET | flush_2IC),
        .rd_index  (req_index),
        .rd_offset (req_offset),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_word0  (rd_word0),
        .rd_word1  (rd_word1),
        .wr_en     (wr_en),
        .wr_index  (fill_addr_q[LINE_ADDR_LSB +: IDX_W]),
        .wr_tag    (fill_addr_q[31 -: TAG_W]),
        .wr_line   (block_read_fIM),
        .wr_valid  (wr_valid)
    );

    // Hits are only served from IDLE; FILL stalls the fetch stage.
    assign hit = (state_q == IDLE) && rd_valid && (rd_tag == req_tag);

    // Next-state, refill handshake and line-install decisions.
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        discard_d   = discard_q;
        wr_en       = 1'b0;
        wr_valid    = 1'b0;
        unique case (state_q)
            IDLE: begin
                discard_d = 1'b0;
                if (!hit) begin
                    state_d     = FILL;
                    fill_addr_d = Instr_address_2IC[31:5];
                end
            end
            FILL: begin
                // A flush seen anywhere in the fill poisons the line being installed.
                discard_d = discard_q | flush_2IC;
                if (block_read_fIM_valid && !RESET) begin
                    wr_en     = 1'b1;
                    wr_valid  = !(discard_q || flush_2IC);
                    state_d   = IDLE;
                    discard_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Memory-side outputs follow the next state so they come straight from flops.
        iblk_read_d = (state_d == FILL);
        addr_im_d   = (state_d == FILL) ? {fill_addr_d, 5'b0} : 32'h0;
    end

    // FSM state, fill address, discard flag and registered memory-side outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            fill_addr_q <= '0;
            discard_q   <= 1'b0;
            iblk_read_q <= 1'b0;
            addr_im_q   <= '0;
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            discard_q   <= discard_d;
            iblk_read_q <= iblk_read_d;
            addr_im_q   <= addr_im_d;
        end
    end

    assign iBlkRead          = iblk_read_q;
    assign Instr_address_2IM = addr_im_q;

    // Fetch-side outputs drive zero whenever they are not valid.
    assign Instr_valid_fIC  = hit;
    assign Instr2_valid_fIC = hit && (req_offset != 3'd7);
    assign Instr1_fIC       = Instr_valid_fIC  ? rd_word0 : 32'h0;
    assign Instr2_fIC       = Instr2_valid_fIC ? rd_word1 : 32'h0;

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus queues expected hits and refill cycles,
// a negedge monitor pops and compares whenever the DUT asserts a valid output.
module tb_icache;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  Instr_address_2IC;
    logic         flush_2IC;
    logic [31:0]  Instr1_fIC, Instr2_fIC;
    logic         Instr_valid_fIC, Instr2_valid_fIC;
    logic [31:0]  Instr_address_2IM;
    logic         iBlkRead;
    logic [255:0] block_read_fIM;
    logic         block_read_fIM_valid;

    always #5 CLK = ~CLK;

    icache #(.NUM_LINES(64)) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .Instr_address_2IC    (Instr_address_2IC),
        .flush_2IC            (flush_2IC),
        .Instr1_fIC           (Instr1_fIC),
        .Instr2_fIC           (Instr2_fIC),
        .Instr_valid_fIC      (Instr_valid_fIC),
        .Instr2_valid_fIC     (Instr2_valid_fIC),
        .Instr_address_2IM    (Instr_address_2IM),
        .iBlkRead             (iBlkRead),
        .block_read_fIM       (block_read_fIM),
        .block_read_fIM_valid (block_read_fIM_valid)
    );

    typedef struct {
        logic [31:0] i1;
        logic        v2;
        logic [31:0] i2;
    } hit_exp_t;

    hit_exp_t    hit_q[$];
    logic [31:0] fill_q[$];
    hit_exp_t    mon_e;
    bit          mon_en = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents: each word is its own address scrambled by a constant.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) begin
            l[32*k +: 32] = mem_word({a[31:5], 5'b0} + 32'(4 * k));
        end
        return l;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One cycle presenting a cached address; the hit is expected in this cycle.
    task automatic hit(input logic [31:0] a);
        hit_exp_t e;
        Instr_address_2IC = a;
        e.i1 = mem_word(a);
        e.v2 = (a[4:2] != 3'd7);
        e.i2 = e.v2 ? mem_word(a + 32'd4) : 32'h0;
        hit_q.push_back(e);
        step();
    endtask

    // Miss on a; memory answers in FILL cycle lat; address 'during' is driven while filling;
    // flush_2IC is pulsed in FILL cycle flush_at (0 = never). Returns in the cycle after install.
    task automatic do_miss(input logic [31:0] a, input int lat, input logic [31:0] during,
                           input int flush_at);
        Instr_address_2IC = a;
        for (int i = 0; i < lat; i++) fill_q.push_back({a[31:5], 5'b0});
        step();
        for (int i = 1; i <= lat; i++) begin
            Instr_address_2IC    = during;
            flush_2IC            = (i == flush_at);
            block_read_fIM_valid = (i == lat);
            block_read_fIM       = (i == lat) ? mem_line(a) : '0;
            step();
        end
        flush_2IC            = 1'b0;
        block_read_fIM_valid = 1'b0;
        block_read_fIM       = '0;
    endtask

    // Monitor: compare against queued expectations whenever the DUT presents a valid output.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (iBlkRead === 1'b1) begin
                if (fill_q.size() == 0) check("unexpected_iBlkRead", 32'(iBlkRead), 32'd0);
                else check("refill_addr", Instr_address_2IM, fill_q.pop_front());
            end
            if (Instr_valid_fIC === 1'b1) begin
                if (hit_q.size() == 0) begin
                    check("unexpected_hit", 32'(Instr_valid_fIC), 32'd0);
                end else begin
                    mon_e = hit_q.pop_front();
                    check("instr1", Instr1_fIC, mon_e.i1);
                    check("instr2_valid", 32'(Instr2_valid_fIC), 32'(mon_e.v2));
                    check("instr2", Instr2_fIC, mon_e.i2);
                end
            end else begin
                check("idle_instr1_zero", Instr1_fIC, 32'h0);
                check("idle_instr2_zero", Instr2_fIC, 32'h0);
                check("idle_instr2_valid", 32'(Instr2_valid_fIC), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET                = 1'b1;
        Instr_address_2IC    = 32'h0;
        flush_2IC            = 1'b0;
        block_read_fIM       = '0;
        block_read_fIM_valid = 1'b0;
        step();
        mon_en = 1'b1;
        @(negedge CLK);
        check("rst_iBlkRead", 32'(iBlkRead), 32'd0);
        check("rst_addr_im", Instr_address_2IM, 32'h0);
        check("rst_valid", 32'(Instr_valid_fIC), 32'd0);
        step();
        RESET = 1'b0;

        // Cold miss with 3-cycle memory, then hits incl. Instr2 at offset 5 and end of line.
        do_miss(32'h0040_0000, 3, 32'h0040_0000, 0);
        hit(32'h0040_0000);
        hit(32'h0040_0014);
        hit(32'h0040_001C);

        // Conflict eviction on index 0.
        do_miss(32'h0040_0800, 2, 32'h0040_0800, 0);
        hit(32'h0040_0800);
        do_miss(32'h0040_0000, 1, 32'h0040_0000, 0);
        hit(32'h0040_0004);

        // Address change during FILL is ignored; new address misses afterwards.
        do_miss(32'h0040_0020, 3, 32'h0040_0100, 0);
        do_miss(32'h0040_0100, 2, 32'h0040_0100, 0);
        hit(32'h0040_0100);
        hit(32'h0040_0024);

        // Flush mid-fill: line discarded, refetch misses; earlier lines also gone.
        do_miss(32'h0040_0040, 3, 32'h0040_0040, 1);
        do_miss(32'h0040_0040, 1, 32'h0040_0040, 0);
        hit(32'h0040_0040);
        do_miss(32'h0040_0020, 1, 32'h0040_0020, 0);
        hit(32'h0040_0020);

        // Flush on the same edge as the memory response: flush wins.
        do_miss(32'h0040_0060, 2, 32'h0040_0060, 2);
        do_miss(32'h0040_0060, 1, 32'h0040_0060, 0);
        hit(32'h0040_0068);

        // Flush while idle: hit this cycle, cached lines miss afterwards.
        flush_2IC = 1'b1;
        hit(32'h0040_0068);
        flush_2IC = 1'b0;
        do_miss(32'h0040_0060, 2, 32'h0040_0060, 0);
        hit(32'h0040_007C);
        do_miss(32'h0040_0040, 1, 32'h0040_0040, 0);
        hit(32'h0040_0048);

        // Reset mid-fill, late memory valid in IDLE is ignored, A not installed.
        Instr_address_2IC = 32'h0040_0200;
        fill_q.push_back(32'h0040_0200);
        step();
        RESET = 1'b1;
        step();
        RESET                = 1'b0;
        Instr_address_2IC    = 32'h0040_0300;
        block_read_fIM_valid = 1'b1;
        block_read_fIM       = mem_line(32'h0040_0200);
        fill_q.push_back(32'h0040_0300);
        @(negedge CLK);
        check("rst_mid_iBlkRead", 32'(iBlkRead), 32'd0);
        check("rst_mid_addr_im", Instr_address_2IM, 32'h0);
        step();
        block_read_fIM_valid = 1'b1;
        block_read_fIM       = mem_line(32'h0040_0300);
        step();
        block_read_fIM_valid = 1'b0;
        block_read_fIM       = '0;
        hit(32'h0040_0300);
        do_miss(32'h0040_0200, 1, 32'h0040_0200, 0);
        hit(32'h0040_020C);

        mon_en = 1'b0;
        check("hit_queue_drained", 32'(hit_q.size()), 32'd0);
        check("fill_queue_drained", 32'(fill_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
